// File: rtl/sample_collector.sv
// Sample collector: arms a set of pin controllers over a register bus, polls their
// sample counters, and queues new samples (pin, count, value) in a FWFT FIFO.
module sample_collector #(
  parameter int NUM_PINS   = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                stop,
  input  logic [NUM_PINS-1:0] pin_mask,
  output logic                bus_enable,
  output logic [18:0]         bus_addr,
  output logic                bus_wr,
  output logic                bus_rd,
  output logic [15:0]         bus_data_out,
  input  logic [15:0]         bus_data_in,
  output logic                smp_valid,
  input  logic                smp_ready,
  output logic [31:0]         smp_data,
  output logic                busy,
  output logic                overflow
);

  localparam int PW = (NUM_PINS > 1) ? $clog2(NUM_PINS) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [7:0]  REG_LOCAL_CMD  = 8'd5;
  localparam logic [7:0]  REG_SAMPLE     = 8'd7;
  localparam logic [7:0]  REG_SAMPLE_CNT = 8'd8;
  localparam logic [15:0] CMD_INPUT_STREAM = 16'd3;
  localparam logic [15:0] CMD_RESET        = 16'd5;

  typedef enum logic [2:0] {IDLE, ARM, POLL, FETCH, DISARM} state_t;

  state_t                state;
  logic [NUM_PINS-1:0]   mask;
  logic [PW-1:0]         pin;
  logic                  stop_pending;
  logic [15:0]           captured;
  logic [15:0]           last_count [NUM_PINS];

  logic [AW:0]           wr_ptr, rd_ptr;
  logic [31:0]           mem [FIFO_DEPTH];
  logic                  empty, full, push, pop, stop_now;
  logic [PW-1:0]         lowest;
  logic [PW:0]           nxt;   // {wrapped, index}
  logic [31:0]           fetch_word;

  function automatic logic [PW-1:0] lowest_bit(input logic [NUM_PINS-1:0] m);
    lowest_bit = '0;
    for (int i = NUM_PINS - 1; i >= 0; i--)
      if (m[i]) lowest_bit = PW'(i);
  endfunction

  // Next set bit above p; wraps to the lowest set bit with the wrap flag raised.
  function automatic logic [PW:0] next_bit(input logic [NUM_PINS-1:0] m, input logic [PW-1:0] p);
    next_bit = {1'b1, lowest_bit(m)};
    for (int i = NUM_PINS - 1; i >= 0; i--)
      if (m[i] && PW'(i) > p) next_bit = {1'b0, PW'(i)};
  endfunction

  assign lowest     = lowest_bit(mask);
  assign nxt        = next_bit(mask, pin);
  assign stop_now   = stop_pending | stop;
  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push       = (state == FETCH) && !full;
  assign pop        = !empty && smp_ready;
  assign fetch_word = {8'(pin), captured[7:0], bus_data_in};
  assign smp_valid  = !empty;
  assign smp_data   = empty ? 32'd0 : mem[rd_ptr[AW-1:0]];
  assign busy       = (state != IDLE);

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latch).
  always_comb begin
    bus_enable   = 1'b0;
    bus_wr       = 1'b0;
    bus_rd       = 1'b0;
    bus_addr     = '0;
    bus_data_out = '0;
    case (state)
      ARM, DISARM: begin
        bus_enable   = 1'b1;
        bus_wr       = 1'b1;
        bus_addr     = {11'(pin), REG_LOCAL_CMD};
        bus_data_out = (state == ARM) ? CMD_INPUT_STREAM : CMD_RESET;
      end
      POLL, FETCH: begin
        bus_enable = 1'b1;
        bus_rd     = 1'b1;
        bus_addr   = {11'(pin), (state == POLL) ? REG_SAMPLE_CNT : REG_SAMPLE};
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      mask         <= '0;
      pin          <= '0;
      stop_pending <= 1'b0;
      overflow     <= 1'b0;
      captured     <= '0;
      for (int i = 0; i < NUM_PINS; i++) last_count[i] <= '0;
    end else begin
      case (state)
        IDLE: if (start && |pin_mask) begin
          mask         <= pin_mask;
          pin          <= lowest_bit(pin_mask);
          overflow     <= 1'b0;
          stop_pending <= 1'b0;
          for (int i = 0; i < NUM_PINS; i++) last_count[i] <= '0;
          state        <= ARM;
        end
        ARM: begin
          if (stop) stop_pending <= 1'b1;
          pin <= nxt[PW-1:0];
          if (nxt[PW]) state <= POLL;
        end
        POLL: begin
          if (stop) stop_pending <= 1'b1;
          if (stop_now) begin
            pin   <= lowest;
            state <= DISARM;
          end else if (bus_data_in != last_count[pin]) begin
            captured <= bus_data_in;
            state    <= FETCH;
          end else begin
            pin <= nxt[PW-1:0];
          end
        end
        FETCH: begin
          if (stop) stop_pending <= 1'b1;
          if (full) overflow <= 1'b1;
          last_count[pin] <= captured;
          if (stop_now) begin
            pin   <= lowest;
            state <= DISARM;
          end else begin
            pin   <= nxt[PW-1:0];
            state <= POLL;
          end
        end
        DISARM: begin
          pin <= nxt[PW-1:0];
          if (nxt[PW]) begin
            state        <= IDLE;
            stop_pending <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: FIFO storage is not reset; the pointers alone define validity and smp_data is gated.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= fetch_word;
  end

endmodule

// File: tb/tb_sample_collector.sv
// Directed bench for sample_collector: pin-controller register model on the bus,
// scoreboard queue of expected FIFO words checked as the consumer drains them.
module tb_sample_collector;

  logic        clk = 1'b0;
  logic        reset, start, stop, smp_ready;
  logic [7:0]  pin_mask;
  logic        bus_enable, bus_wr, bus_rd, smp_valid, busy, overflow;
  logic [18:0] bus_addr;
  logic [15:0] bus_data_out, bus_data_in;
  logic [31:0] smp_data;

  logic [15:0] cnt  [16];
  logic [15:0] sreg [16];
  logic [31:0] sb [$];
  int vectors = 0;
  int miscompares = 0;

  sample_collector #(.NUM_PINS(8), .FIFO_DEPTH(16)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .pin_mask(pin_mask),
    .bus_enable(bus_enable), .bus_addr(bus_addr), .bus_wr(bus_wr), .bus_rd(bus_rd),
    .bus_data_out(bus_data_out), .bus_data_in(bus_data_in),
    .smp_valid(smp_valid), .smp_ready(smp_ready), .smp_data(smp_data),
    .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Pin controllers answer reads combinationally.
  always_comb begin
    bus_data_in = '0;
    if (bus_rd) begin
      if (bus_addr[7:0] == 8'h08)      bus_data_in = cnt[bus_addr[11:8]];
      else if (bus_addr[7:0] == 8'h07) bus_data_in = sreg[bus_addr[11:8]];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_bus(input string tag, input logic wr, input logic rd,
                         input logic [18:0] addr, input logic [15:0] data);
    chk({tag, "_bus"}, {bus_enable, bus_wr, bus_rd, bus_addr, bus_data_out},
        {(wr | rd), wr, rd, addr, data});
  endtask

  task automatic drain_one();
    logic [31:0] e;
    e = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD_BEEF;
    chk("drain_valid", {31'd0, smp_valid}, 32'd1);
    chk("drain_data", smp_data, e);
    smp_ready = 1'b1;
    tick();
    smp_ready = 1'b0;
  endtask

  task automatic count_fetches(input logic [18:0] a, input int cycles, output int f);
    f = 0;
    for (int i = 0; i < cycles; i++) begin
      if (bus_rd && bus_addr == a) f++;
      tick();
    end
  endtask

  task automatic wait_fetch(input logic [18:0] a);
    int n;
    n = 0;
    while (!(bus_rd && bus_addr == a) && n < 40) begin
      tick();
      n++;
    end
    chk("fetch_seen", {31'd0, (bus_rd && bus_addr == a)}, 32'd1);
  endtask

  initial begin
    int f, fetches, n;
    logic pend;
    for (int i = 0; i < 16; i++) begin
      cnt[i]  = '0;
      sreg[i] = '0;
    end
    reset = 1'b1; start = 1'b0; stop = 1'b0; smp_ready = 1'b0; pin_mask = '0;
    tick(); tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk_bus("rst", 1'b0, 1'b0, 19'h0, 16'h0);
    chk("rst_valid", {31'd0, smp_valid}, 32'd0);
    chk("rst_data", smp_data, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    reset = 1'b0;

    // Arm pins 0 and 2, then alternating polls.
    pin_mask = 8'b0000_0101;
    start = 1'b1; tick(); start = 1'b0;
    chk("arm_busy", {31'd0, busy}, 32'd1);
    chk_bus("arm0", 1'b1, 1'b0, 19'h005, 16'd3);
    tick(); chk_bus("arm2", 1'b1, 1'b0, 19'h205, 16'd3);
    tick(); chk_bus("poll0", 1'b0, 1'b1, 19'h008, 16'd0);
    tick(); chk_bus("poll2", 1'b0, 1'b1, 19'h208, 16'd0);
    tick(); chk_bus("poll0b", 1'b0, 1'b1, 19'h008, 16'd0);

    // Single count change on pin 2 -> exactly one fetch and one FIFO word.
    cnt[2] = 16'd1; sreg[2] = 16'h0001; sb.push_back(32'h0201_0001);
    count_fetches(19'h207, 12, f);
    chk("one_fetch_p2", f, 32'd1);
    drain_one();
    chk("empty_after_p2", {31'd0, smp_valid}, 32'd0);

    // Counter wrap 0xFFFF -> 0x0000 is a change.
    cnt[0] = 16'hFFFF; sreg[0] = 16'hAAAA; sb.push_back(32'h00FF_AAAA);
    count_fetches(19'h007, 12, f);
    chk("fetch_ffff", f, 32'd1);
    cnt[0] = 16'h0000; sreg[0] = 16'h5555; sb.push_back(32'h0000_5555);
    count_fetches(19'h007, 12, f);
    chk("fetch_wrap", f, 32'd1);
    drain_one();
    drain_one();

    // Overflow: pin 2 changes after every fetch with the consumer stalled.
    cnt[2] = 16'd2; sreg[2] = 16'd2;
    for (int k = 2; k <= 17; k++) sb.push_back({8'd2, 8'(k), 16'(k)});
    fetches = 0; pend = 1'b0;
    for (int i = 0; i < 600 && fetches < 17; i++) begin
      tick();
      if (pend) begin
        cnt[2]++; sreg[2]++; pend = 1'b0;
      end
      if (bus_rd && bus_addr == 19'h207) begin
        fetches++;
        pend = 1'b1;
      end
    end
    chk("ovf_fetches", fetches, 32'd17);
    chk("ovf_before", {31'd0, overflow}, 32'd0);
    tick();
    chk("ovf_set", {31'd0, overflow}, 32'd1);
    for (int i = 0; i < 16; i++) drain_one();
    chk("ovf_drained", {31'd0, smp_valid}, 32'd0);
    chk("ovf_sticky", {31'd0, overflow}, 32'd1);

    // Reset in the middle of a FETCH with three words queued.
    cnt[0] = 16'h0033; wait_fetch(19'h007); tick();
    cnt[2] = 16'h0040; wait_fetch(19'h207); tick();
    cnt[0] = 16'h0034; wait_fetch(19'h007); tick();
    chk("pre_rst_valid", {31'd0, smp_valid}, 32'd1);
    cnt[2] = 16'h0041; wait_fetch(19'h207);
    reset = 1'b1; tick();
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk_bus("mid_rst", 1'b0, 1'b0, 19'h0, 16'h0);
    chk("mid_rst_valid", {31'd0, smp_valid}, 32'd0);
    chk("mid_rst_data", smp_data, 32'd0);
    chk("mid_rst_ovf", {31'd0, overflow}, 32'd0);
    reset = 1'b0; tick();
    chk("post_rst_busy", {31'd0, busy}, 32'd0);

    // Stop during POLL -> DISARM sequence, then IDLE.
    for (int i = 0; i < 16; i++) cnt[i] = '0;
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    chk_bus("poll_b4_stop", 1'b0, 1'b1, 19'h008, 16'd0);
    stop = 1'b1; tick(); stop = 1'b0;
    n = 0;
    while (!bus_wr && n < 4) begin
      tick();
      n++;
    end
    chk_bus("disarm0", 1'b1, 1'b0, 19'h005, 16'd5);
    tick(); chk_bus("disarm2", 1'b1, 1'b0, 19'h205, 16'd5);
    tick();
    chk("stop_idle", {31'd0, busy}, 32'd0);
    chk_bus("stop_idle", 1'b0, 1'b0, 19'h0, 16'h0);

    // Stop during ARM: arming completes, one POLL runs, then DISARM.
    start = 1'b1; tick(); start = 1'b0;
    stop = 1'b1; tick(); stop = 1'b0;
    chk_bus("armstop_arm2", 1'b1, 1'b0, 19'h205, 16'd3);
    tick(); chk_bus("armstop_poll", 1'b0, 1'b1, 19'h008, 16'd0);
    tick(); chk_bus("armstop_dis0", 1'b1, 1'b0, 19'h005, 16'd5);
    tick(); chk_bus("armstop_dis2", 1'b1, 1'b0, 19'h205, 16'd5);
    tick(); chk("armstop_idle", {31'd0, busy}, 32'd0);

    // Start with an empty mask is ignored; start with stop in IDLE acts as start.
    pin_mask = '0;
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    chk("mask0_ignored", {31'd0, busy}, 32'd0);
    pin_mask = 8'b0000_0101;
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    chk_bus("start_stop", 1'b1, 1'b0, 19'h005, 16'd3);
    stop = 1'b1; tick(); stop = 1'b0;
    n = 0;
    while (busy && n < 10) begin
      tick();
      n++;
    end
    chk("final_idle", {31'd0, busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
